mat_mult_seq: RTL and testbench

Sequencer for the N x N matrix-multiply datapath: a single MAC unit fed by A and B operand RAMs, with results written to a C RAM. It walks the i/j/k loop nest and issues operand read addresses. It aligns MAC clear/enable with the RAM read latency and issues result write strobes. A level start/done handshake is provided to the top-level controller, plus a cycle counter for performance measurement.

---
 rtl/mat_mult_seq.sv | 144 ++++++++++++++
 tb/tb_mat_mult_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq.sv
// Loop-nest sequencer for a single-MAC N x N matrix multiply: issues A/B reads,
// aligns MAC clear/enable with RAM latency, and strobes C writes in row-major order.
module mat_mult_seq #(
    parameter int N       = 8,
    parameter int LOG2N   = 3,
    parameter int RAM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [2*LOG2N-1:0]   a_addr,
    output logic [2*LOG2N-1:0]   b_addr,
    output logic                 mac_en,
    output logic                 mac_clr,
    output logic                 c_we,
    output logic [2*LOG2N-1:0]   c_addr,
    output logic [CNT_W-1:0]     cycle_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic             first;
        logic             last;
        logic [LOG2N-1:0] i;
        logic [LOG2N-1:0] j;
    } tag_t;

    localparam int               DW         = $clog2(RAM_LAT + 2);
    localparam logic [LOG2N-1:0] IDX_MAX    = LOG2N'(N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(RAM_LAT);

    state_t             state, state_nxt;
    logic [LOG2N-1:0]   i, j, k;
    logic [DW-1:0]      drain_cnt;
    logic               last_issue;
    tag_t               issue_tag;
    tag_t               pipe [RAM_LAT];
    logic               wr_vld;
    logic [2*LOG2N-1:0] wr_addr;

    assign last_issue = (i == IDX_MAX) && (j == IDX_MAX) && (k == IDX_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign a_addr = rd_en ? {i, k} : '0;
    assign b_addr = rd_en ? {k, j} : '0;

    // Indices sit at zero outside ISSUE, so entry into ISSUE always starts at (0,0,0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i           <= '0;
            j           <= '0;
            k           <= '0;
            drain_cnt   <= '0;
            cycle_count <= '0;
        end else begin
            if (state == ISSUE && !abort) begin
                k <= k + 1'b1;
                if (k == IDX_MAX) begin
                    j <= j + 1'b1;
                    if (j == IDX_MAX) i <= i + 1'b1;
                end
            end else begin
                i <= '0;
                j <= '0;
                k <= '0;
            end
            drain_cnt <= (state == DRAIN && !abort) ? drain_cnt + 1'b1 : '0;
            if (state == IDLE && start && !abort)
                cycle_count <= '0;
            else if ((state == ISSUE || state == DRAIN) && !abort)
                cycle_count <= cycle_count + 1'b1;
        end
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.vld   = rd_en;
        issue_tag.first = (k == '0);
        issue_tag.last  = (k == IDX_MAX);
        issue_tag.i     = i;
        issue_tag.j     = j;
    end

    // One extra register after the tag pipe: the accumulator holds the final sum
    // one cycle after the last mac_en of an output element.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < RAM_LAT; s++) pipe[s] <= '0;
            wr_vld  <= 1'b0;
            wr_addr <= '0;
        end else begin
            pipe[0] <= issue_tag;
            for (int s = 1; s < RAM_LAT; s++) pipe[s] <= pipe[s-1];
            wr_vld  <= pipe[RAM_LAT-1].vld && pipe[RAM_LAT-1].last;
            wr_addr <= {pipe[RAM_LAT-1].i, pipe[RAM_LAT-1].j};
            if (abort) begin
                for (int s = 0; s < RAM_LAT; s++) pipe[s].vld <= 1'b0;
                wr_vld <= 1'b0;
            end
        end
    end

    assign mac_en  = pipe[RAM_LAT-1].vld;
    assign mac_clr = pipe[RAM_LAT-1].vld && pipe[RAM_LAT-1].first;
    assign c_we    = wr_vld;
    assign c_addr  = wr_vld ? wr_addr : '0;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq: N=8/RAM_LAT=1 and N=2/RAM_LAT=3 instances.
module tb_mat_mult_seq;

    localparam int FIRST_WE_LAG8 = 7 + 1 + 1;  // k=N-1 issue offset, then RAM_LAT+1

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start8, abort8, busy8, done8, rd_en8, mac_en8, mac_clr8, c_we8;
    logic [5:0] a_addr8, b_addr8, c_addr8;
    logic [15:0] cnt8;

    logic       start2, abort2, busy2, done2, rd_en2, mac_en2, mac_clr2, c_we2;
    logic [1:0] a_addr2, b_addr2, c_addr2;
    logic [15:0] cnt2;

    mat_mult_seq #(.N(8), .LOG2N(3), .RAM_LAT(1), .CNT_W(16)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .abort(abort8),
        .busy(busy8), .done(done8), .rd_en(rd_en8),
        .a_addr(a_addr8), .b_addr(b_addr8),
        .mac_en(mac_en8), .mac_clr(mac_clr8),
        .c_we(c_we8), .c_addr(c_addr8), .cycle_count(cnt8)
    );

    mat_mult_seq #(.N(2), .LOG2N(1), .RAM_LAT(3), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .rd_en(rd_en2),
        .a_addr(a_addr2), .b_addr(b_addr2),
        .mac_en(mac_en2), .mac_clr(mac_clr2),
        .c_we(c_we2), .c_addr(c_addr2), .cycle_count(cnt2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Event monitors, sampled on the falling edge
    int cyc = 0;
    int m_busy, m_rd, m_mac, m_clr, m_we, m_err, m_done, f_rd, f_we, s_we;
    logic [5:0] probe_a [3];
    logic [5:0] probe_b [3];
    int m2_rd, m2_mac, m2_we, m2_err, f2_rd, f2_mac, f2_we;

    always @(negedge clk) begin
        cyc++;
        if (busy8) m_busy++;
        if (done8) m_done++;
        if (rd_en8) begin
            if (m_rd == 0) f_rd = cyc;
            if (m_rd < 3) begin
                probe_a[m_rd] = a_addr8;
                probe_b[m_rd] = b_addr8;
            end
            m_rd++;
        end
        if (mac_en8) m_mac++;
        if (mac_en8 && mac_clr8) m_clr++;
        if (c_we8) begin
            if (c_addr8 != m_we[5:0]) m_err++;
            if (m_we == 0) f_we = cyc;
            if (m_we == 1) s_we = cyc;
            m_we++;
        end else if (c_addr8 != 6'd0) m_err++;

        if (rd_en2) begin
            if (m2_rd == 0) f2_rd = cyc;
            m2_rd++;
        end
        if (mac_en2) begin
            if (m2_mac == 0) f2_mac = cyc;
            m2_mac++;
        end
        if (c_we2) begin
            if (c_addr2 != m2_we[1:0]) m2_err++;
            if (m2_we == 0) f2_we = cyc;
            m2_we++;
        end
    end

    task automatic clr_mon8();
        m_busy = 0; m_rd = 0; m_mac = 0; m_clr = 0; m_we = 0;
        m_err = 0; m_done = 0; f_rd = 0; f_we = 0; s_we = 0;
    endtask

    task automatic finish_run8(input string tag);
        for (int c = 0; c < 2000 && !done8; c++) @(posedge clk) #1;
        check({tag, " done"}, done8, 1);
        check({tag, " busy_cycles"}, m_busy, 514);
        check({tag, " rd_en"}, m_rd, 512);
        check({tag, " mac_en"}, m_mac, 512);
        check({tag, " mac_clr"}, m_clr, 64);
        check({tag, " c_we"}, m_we, 64);
        check({tag, " c_addr_order"}, m_err, 0);
        check({tag, " cycle_count"}, cnt8, 514);
        check({tag, " addr0"}, {probe_a[0], probe_b[0]}, {6'd0, 6'd0});
        check({tag, " addr1"}, {probe_a[1], probe_b[1]}, {6'd1, 6'd8});
        check({tag, " addr2"}, {probe_a[2], probe_b[2]}, {6'd2, 6'd16});
        check({tag, " first_we_lag"}, f_we - f_rd, FIRST_WE_LAG8);
        check({tag, " second_we_gap"}, s_we - f_we, 8);
    endtask

    task automatic full_run8(input string tag);
        clr_mon8();
        start8 = 1'b1;
        finish_run8(tag);
    endtask

    initial begin
        int rd_snap, mac_snap, we_snap;
        reset = 1'b1;
        start8 = 1'b0; abort8 = 1'b0; start2 = 1'b0; abort2 = 1'b0;
        m2_rd = 0; m2_mac = 0; m2_we = 0; m2_err = 0; f2_rd = 0; f2_mac = 0; f2_we = 0;
        clr_mon8();
        #12;
        check("reset outputs", {busy8, done8, rd_en8, a_addr8, b_addr8, mac_en8, mac_clr8, c_we8, c_addr8}, 0);
        check("reset count", cnt8, 0);
        @(posedge clk) #2 reset = 1'b0;
        @(posedge clk) #1;
        check("idle outputs", {busy8, done8, rd_en8, mac_en8, c_we8, busy2, done2}, 0);

        // N=2, RAM_LAT=3
        start2 = 1'b1;
        for (int c = 0; c < 200 && !done2; c++) @(posedge clk) #1;
        check("n2 done", done2, 1);
        check("n2 rd_en", m2_rd, 8);
        check("n2 mac_en", m2_mac, 8);
        check("n2 mac_lag", f2_mac - f2_rd, 3);
        check("n2 we_lag", f2_we - (f2_rd + 1), 4);
        check("n2 c_we", m2_we, 4);
        check("n2 c_addr_order", m2_err, 0);
        check("n2 cycle_count", cnt2, 12);
        start2 = 1'b0;

        // N=8 full run, first-cycle probes included
        full_run8("run1");

        // start held through DONE, then drop and rise
        rd_snap = m_rd;
        repeat (20) @(posedge clk);
        #1;
        check("hold done", done8, 1);
        check("hold no rd_en", m_rd - rd_snap, 0);
        check("hold count", cnt8, 514);
        start8 = 1'b0;
        @(posedge clk) #1;
        check("drop idle", {busy8, done8}, 0);
        full_run8("run2");

        // abort at ISSUE cycle 100
        start8 = 1'b0;
        @(posedge clk) #1;
        clr_mon8();
        start8 = 1'b1;
        @(posedge clk) #1;
        repeat (100) @(posedge clk);
        #1;
        check("pre-abort busy", busy8, 1);
        abort8 = 1'b1;
        start8 = 1'b0;
        @(posedge clk) #1;
        abort8 = 1'b0;
        check("abort idle", {busy8, done8, rd_en8}, 0);
        check("abort rd_en", m_rd, 101);
        check("abort count", cnt8, 100);
        mac_snap = m_mac;
        we_snap = m_we;
        repeat (30) @(posedge clk);
        #1;
        check("abort no mac_en", m_mac - mac_snap, 0);
        check("abort no c_we", m_we - we_snap, 0);
        check("abort no done", m_done, 0);
        check("abort count held", cnt8, 100);

        // asynchronous reset at ISSUE cycle 37
        start8 = 1'b1;
        @(posedge clk) #1;
        repeat (37) @(posedge clk);
        #3;
        check("pre-reset busy", {busy8, rd_en8, mac_en8}, 3'b111);
        reset = 1'b1;
        #1;
        check("async reset outputs", {busy8, done8, rd_en8, a_addr8, b_addr8, mac_en8, mac_clr8, c_we8, c_addr8}, 0);
        check("async reset count", cnt8, 0);
        #3;
        clr_mon8();
        reset = 1'b0;
        finish_run8("rst_run");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
